// File: rtl/apb_mem_slave.sv
// APB memory completer: word-addressed register array behind a
// wait-state FSM with a registered one-cycle PREADY pulse.
module apb_mem_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 21
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [7:0]        PADDR,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1
                         : $clog2(WAIT_CYCLES + 1);
    localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_addr;
    logic               r_write;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_capture;
    logic               w_dec;
    logic               w_complete;
    logic               w_done;
    logic               w_in_range;
    logic [IDX_W-1:0]   w_idx;

    // Range check uses 9 bits so DEPTH=256 compares correctly.
    assign w_in_range = ({1'b0, r_addr} < 9'(DEPTH));
    assign w_idx      = r_addr[IDX_W-1:0];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (PSEL) w_next = S_WAIT;
            S_WAIT: begin
                if (!PSEL)           w_next = S_IDLE;
                else if (w_complete) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture  = 1'b0;
        w_dec      = 1'b0;
        w_complete = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE: w_capture = PSEL;
            S_WAIT: begin
                if (PSEL && PENABLE) begin
                    if (r_cnt == '0) w_complete = 1'b1;
                    else             w_dec      = 1'b1;
                end
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_capture) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
                r_cnt   <= CNT_W'(WAIT_CYCLES);
            end
            if (w_dec) r_cnt <= r_cnt - CNT_W'(1);
            if (w_complete) begin
                PREADY  <= 1'b1;
                PSLVERR <= !w_in_range;
                if (w_in_range && r_write) r_mem[w_idx] <= r_wdata;
                if (!r_write) PRDATA <= w_in_range ? r_mem[w_idx] : '0;
            end
            if (w_done) begin
                PREADY  <= 1'b0;
                PSLVERR <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (2 and 0 wait states) driven by
// directed and random APB transfers, checked against a transaction model.
module tb_apb_mem_slave;
    localparam int DEPTH = 64;
    localparam int DW    = 21;

    logic          clk = 1'b0;
    logic          preset;
    logic          psel    [2];
    logic          penable [2];
    logic [7:0]    paddr   [2];
    logic          pwrite  [2];
    logic [DW-1:0] pwdata  [2];
    logic [DW-1:0] prdata  [2];
    logic          pready  [2];
    logic          pslverr [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   run    = 1'b0;
    int   wcyc   [2] = '{2, 0};

    logic [DW-1:0] mem_m   [2][DEPTH];
    logic          exp_rdy [2];
    logic          exp_err [2];
    logic [DW-1:0] exp_rd  [2];

    int   rise_cyc [2];
    int   rise_cnt [2] = '{0, 0};
    logic rise_err [2];
    logic prev_rdy [2] = '{1'b0, 1'b0};
    int   s_cyc;

    apb_mem_slave #(
        .DEPTH(DEPTH), .WAIT_CYCLES(2), .DATA_W(DW)
    ) u_dut_w2 (
        .PCLK(clk), .PRESET(preset),
        .PSEL(psel[0]), .PENABLE(penable[0]),
        .PADDR(paddr[0]), .PWRITE(pwrite[0]),
        .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_mem_slave #(
        .DEPTH(DEPTH), .WAIT_CYCLES(0), .DATA_W(DW)
    ) u_dut_w0 (
        .PCLK(clk), .PRESET(preset),
        .PSEL(psel[1]), .PENABLE(penable[1]),
        .PADDR(paddr[1]), .PWRITE(pwrite[1]),
        .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pready%0d", k), 32'(pready[k]),
                    32'(exp_rdy[k]));
                chk($sformatf("pslverr%0d", k), 32'(pslverr[k]),
                    32'(exp_err[k]));
                chk($sformatf("prdata%0d", k), 32'(prdata[k]),
                    32'(exp_rd[k]));
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pready[k] === 1'b1 && prev_rdy[k] !== 1'b1) begin
                rise_cyc[k] = cyc;
                rise_err[k] = pslverr[k];
                rise_cnt[k] = rise_cnt[k] + 1;
            end
            prev_rdy[k] = pready[k];
        end
    end

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < DEPTH; a++) mem_m[k][a] = '0;
            exp_rdy[k] = 1'b0;
            exp_err[k] = 1'b0;
            exp_rd[k]  = '0;
        end
    endtask

    // Called at posedge+1 with the bus idle; returns at posedge+1 with the
    // bus idle and the slave back in IDLE.
    task automatic xfer(input int k, input bit wr, input logic [7:0] a,
                        input logic [DW-1:0] d, input int abort_after,
                        input int stall_pct);
        int  acc;
        int  iters;
        bit  stall;
        bit  err;
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = a;
        pwdata[k]  = d;
        @(posedge clk); #1;
        s_cyc = cyc;
        acc   = 0;
        iters = 0;
        forever begin
            if (abort_after >= 0 && acc == abort_after) begin
                psel[k]    = 1'b0;
                penable[k] = 1'b0;
                @(posedge clk); #1;
                return;
            end
            stall = (iters < 50) && ($urandom_range(0, 99) < stall_pct);
            penable[k] = !stall;
            iters++;
            @(posedge clk); #1;
            if (!stall) begin
                acc++;
                if (acc == wcyc[k] + 1) break;
            end
        end
        err = (int'(a) >= DEPTH);
        exp_rdy[k] = 1'b1;
        exp_err[k] = err;
        if (!err && wr) mem_m[k][a] = d;
        if (!wr) exp_rd[k] = err ? '0 : mem_m[k][a];
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
        @(posedge clk); #1;
        exp_rdy[k] = 1'b0;
        exp_err[k] = 1'b0;
    endtask

    initial begin
        int base;
        preset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; paddr[k] = '0;
            pwrite[k] = 1'b0; pwdata[k] = '0;
        end
        reset_model();
        #1 preset = 1'b1;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_pready", 32'(pready[k]), 32'h0);
            chk("rst_pslverr", 32'(pslverr[k]), 32'h0);
            chk("rst_prdata", 32'(prdata[k]), 32'h0);
        end
        preset = 1'b0;

        // reset during a write in WAIT
        xfer(0, 1, 8'h03, 21'h00155, -1, 0);
        xfer(0, 0, 8'h03, '0, -1, 0);
        chk("t1_pre_rd", 32'(prdata[0]), 32'h155);
        psel[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h03;
        pwdata[0] = 21'h00777; penable[0] = 1'b0;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        reset_model();
        #1;
        chk("t1_rst_rdy", 32'(pready[0]), 32'h0);
        chk("t1_rst_rd", 32'(prdata[0]), 32'h0);
        @(posedge clk); #1;
        preset = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        xfer(0, 0, 8'h03, '0, -1, 0);
        chk("t1_post_rd", 32'(prdata[0]), 32'h0);

        // two wait states
        xfer(0, 1, 8'h05, 21'h1ABCD, -1, 0);
        chk("t2_lat", 32'(rise_cyc[0] - s_cyc), 32'd3);
        chk("t2_err", 32'(rise_err[0]), 32'h0);
        xfer(0, 0, 8'h05, '0, -1, 0);
        chk("t2_rd", 32'(prdata[0]), 32'h1ABCD);

        // zero wait states
        xfer(1, 1, 8'h3F, 21'h1FFFFF, -1, 0);
        chk("t3_wlat", 32'(rise_cyc[1] - s_cyc), 32'd1);
        xfer(1, 0, 8'h3F, '0, -1, 0);
        chk("t3_rlat", 32'(rise_cyc[1] - s_cyc), 32'd1);
        chk("t3_rd", 32'(prdata[1]), 32'h1FFFFF);

        // out of range
        xfer(0, 1, 8'h00, 21'h0BEEF, -1, 0);
        xfer(0, 1, 8'h40, 21'h12345, -1, 0);
        chk("t4_werr", 32'(rise_err[0]), 32'h1);
        xfer(0, 0, 8'h40, '0, -1, 0);
        chk("t4_rerr", 32'(rise_err[0]), 32'h1);
        chk("t4_rd", 32'(prdata[0]), 32'h0);
        xfer(0, 0, 8'h00, '0, -1, 0);
        chk("t4_rd0", 32'(prdata[0]), 32'h0BEEF);

        // master abort
        rise_cyc[0] = -1;
        xfer(0, 1, 8'h10, 21'h00AAA, 1, 0);
        chk("t5_norise", 32'(rise_cyc[0]), 32'hFFFFFFFF);
        xfer(0, 0, 8'h10, '0, -1, 0);
        chk("t5_rd", 32'(prdata[0]), 32'h0);

        // back to back
        base = rise_cnt[1];
        xfer(1, 1, 8'h01, 21'h00001, -1, 0);
        xfer(1, 1, 8'h02, 21'h00002, -1, 0);
        xfer(1, 0, 8'h01, '0, -1, 0);
        chk("t6_rd1", 32'(prdata[1]), 32'h1);
        xfer(1, 0, 8'h02, '0, -1, 0);
        chk("t6_rd2", 32'(prdata[1]), 32'h2);
        chk("t6_pulses", 32'(rise_cnt[1] - base), 32'd4);

        for (int i = 0; i < 300; i++) begin
            int k;
            int ab;
            k  = int'($urandom_range(0, 1));
            ab = ($urandom_range(0, 9) == 0)
               ? int'($urandom_range(0, wcyc[k])) : -1;
            xfer(k, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 79)),
                 DW'($urandom_range(0, (1 << DW) - 1)), ab, 30);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
APB completer (slave) for the memory peripheral: the PSEL_1 target of the subsystem's APB master. It holds a synchronous word-addressed register array. Reads and writes complete after a parameterised number of wait states, with a registered one-cycle PREADY pulse. Out-of-range addresses complete with PSLVERR and no side effects.

Parameters:
DEPTH, 64, number of 21-bit words; legal addresses are 0..DEPTH-1; 1 <= DEPTH <= 256.
WAIT_CYCLES, 2, extra access-phase cycles inserted before PREADY; 0 means zero-wait completion.
DATA_W, 21, word width; must match the master's PWDATA width.

Ports:
PCLK  in  1  APB clock, all logic on rising edge.
PRESET  in  1  reset, asynchronous, active-high.
PSEL  in  1  slave select from master (PSEL_1).
PENABLE  in  1  access-phase indicator.
PADDR  in  8  word address.
PWRITE  in  1  1 = write, 0 = read.
PWDATA  in  DATA_W  write data.
PRDATA  out  DATA_W  read data, registered.
PREADY  out  1  transfer-complete pulse, registered (to master PREADY_1).
PSLVERR  out  1  error flag, valid only while PREADY=1.

Behaviour:
- Reset (async, PRESET=1): PREADY=0, PSLVERR=0, PRDATA=0, all memory words=0, state=IDLE, wait counter=0. Reset mid-transfer aborts the transfer with no write.
- State machine: IDLE, WAIT, DONE. Encoding is 2 bits.
- IDLE:
  - At a PCLK edge with PSEL=1, capture PADDR, PWRITE and PWDATA into internal registers, load the counter with WAIT_CYCLES, then go to WAIT.
  - PENABLE is ignored in IDLE. Any PSEL=1 starts a transfer, for robustness against a master that leaves PENABLE high.
- WAIT:
  - At each edge with PSEL=1 and PENABLE=1 and counter != 0: decrement the counter.
  - At an edge with PSEL=1, PENABLE=1 and counter == 0, complete the transfer:
    - Set PREADY<=1.
    - If the captured address < DEPTH and the transfer is a write: mem[addr] <= captured data. PSLVERR<=0.
    - If the captured address < DEPTH and the transfer is a read: PRDATA <= mem[addr]. PSLVERR<=0.
    - If the captured address >= DEPTH: PSLVERR<=1, no memory change, PRDATA<=0 for reads.
    - Go to DONE.
  - PSEL=1 with PENABLE=0: hold state and counter.
  - PSEL=0 (master abort): go to IDLE, no write, outputs unchanged (PREADY stays 0).
- DONE: at the next edge set PREADY<=0 and PSLVERR<=0, then go to IDLE unconditionally. PREADY is high for exactly one cycle per transfer.
- Latency:
  - Edge S is the setup capture. PREADY rises at edge S+1+WAIT_CYCLES, provided PENABLE=1 at each of those edges.
  - For WAIT_CYCLES=0, PREADY is high in the cycle after the first access edge.
- PRDATA holds its last read value until the next completed read. Writes and errors-on-write do not change PRDATA.
- Back-to-back transfers: a new PSEL is only recognised in IDLE. The minimum spacing is one IDLE cycle after DONE.
- Counter width is max(1, clog2(WAIT_CYCLES+1)). The counter never underflows.
- Memory is DEPTH x DATA_W flops with a single port. Only the low clog2(DEPTH) bits index the array, after the range check on the full 8-bit address.

Test Plan:
1. Assert PRESET while in WAIT during a write to 0x03 -> PREADY=0 and PRDATA=0 immediately. A later read of 0x03 returns 0x000000.
2. WAIT_CYCLES=2: write 0x1ABCD to 0x05 with PENABLE held high -> PREADY=1 for exactly one cycle at edge S+3, PSLVERR=0. A following read of 0x05 gives PRDATA=0x1ABCD with PREADY.
3. WAIT_CYCLES=0: write 0x1FFFFF to 0x3F, then read 0x3F -> each completes in the cycle after the first access edge. PRDATA=0x1FFFFF.
4. DEPTH=64: write 0x12345 to 0x40, then read 0x40 -> both complete with PSLVERR=1 and PREADY=1. Read gives PRDATA=0. A read of 0x00 still returns its prior value.
5. Abort: write 0x00AAA to 0x10, drop PSEL during WAIT -> PREADY never asserts. A read of 0x10 returns its old value (0 after reset).
6. Back-to-back: write 0x00001 to 0x01, write 0x00002 to 0x02, read 0x01, read 0x02 -> four single-cycle PREADY pulses. Reads give 0x00001 then 0x00002.
